// File: rtl/jk_pkg.sv
// Shared types and constants for the JK excitation driver.
// Optional build macro JK_TOGGLE_PREF_EN affects jk_excite_bit only.
package jk_pkg;

  // Sequencer states: accept a target, drive the bank once, check feedback.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  // JK input codes packed as {j,k}.
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_excite_bit.sv
// Per-bit JK excitation: given current q and target t, produce j/k.
// Build macro JK_TOGGLE_PREF_EN: when defined, changing bits use toggle (j=k=1)
// instead of the minimal set/reset drive.
module jk_excite_bit
  import jk_pkg::*;
(
  input  logic q,
  input  logic t,
  output logic j,
  output logic k
);

  logic [1:0] code_next;

  // Map the (q, t) transition onto a JK code.
  always_comb begin
    code_next = JK_HOLD;
    unique case ({q, t})
      2'b00: code_next = JK_HOLD;
`ifdef JK_TOGGLE_PREF_EN
      2'b01: code_next = JK_TOGGLE;
      2'b10: code_next = JK_TOGGLE;
`else
      2'b01: code_next = JK_SET;
      2'b10: code_next = JK_RESET;
`endif
      2'b11: code_next = JK_HOLD;
      default: code_next = JK_HOLD;
    endcase
  end

  assign j = code_next[1];
  assign k = code_next[0];

endmodule

// File: rtl/jk_excitation_driver.sv
// Sequencing master for a bank of WIDTH JK flops: accepts a target Q,
// drives J/K for exactly one enable cycle, then checks the feedback.
// Build macro JK_TOGGLE_PREF_EN selects toggle-preferred excitation (see
// jk_excite_bit); the check path is identical in both builds.
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tgt,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             drv_en,
  output logic             done,
  output logic             match,
  output logic [CNT_W-1:0] err_cnt
);

  state_t             state_reg;
  state_t             state_next;
  logic [WIDTH-1:0]   tgt_reg;
  logic [WIDTH-1:0]   j_reg;
  logic [WIDTH-1:0]   k_reg;
  logic [WIDTH-1:0]   j_calc;
  logic [WIDTH-1:0]   k_calc;
  logic [WIDTH-1:0]   j_next;
  logic [WIDTH-1:0]   k_next;
  logic [CNT_W-1:0]   err_cnt_reg;
  logic               accept;
  logic               q_eq_tgt;

  // One excitation cell per bank bit, fed by the live feedback and new target.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    jk_excite_bit u_bit (
      .q (q_fb[gi]),
      .t (tgt[gi]),
      .j (j_calc[gi]),
      .k (k_calc[gi])
    );
  end

  assign q_eq_tgt = (q_fb == tgt_reg);

  // Next-state and handshake/status decode; outputs are zero unless the
  // current state asserts them.
  always_comb begin
    state_next = state_reg;
    tgt_ready  = 1'b0;
    drv_en     = 1'b0;
    done       = 1'b0;
    match      = 1'b0;
    accept     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        tgt_ready = 1'b1;
        if (tgt_valid) begin
          accept     = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        drv_en     = 1'b1;
        state_next = CHECK;
      end
      CHECK: begin
        done       = 1'b1;
        match      = q_eq_tgt;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // J/K are loaded only on accept, so they are nonzero solely during DRIVE.
  always_comb begin
    j_next = '0;
    k_next = '0;
    if (accept) begin
      j_next = j_calc;
      k_next = k_calc;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Target capture and registered J/K drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_reg <= '0;
      j_reg   <= '0;
      k_reg   <= '0;
    end else begin
      if (accept) begin
        tgt_reg <= tgt;
      end
      j_reg <= j_next;
      k_reg <= k_next;
    end
  end

  // Saturating count of transfers whose feedback missed the target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_reg <= '0;
    end else if (state_reg == CHECK && !q_eq_tgt && err_cnt_reg != {CNT_W{1'b1}}) begin
      err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign j       = j_reg;
  assign k       = k_reg;
  assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Self-checking bench for jk_excitation_driver with a behavioural JK bank.
// Honours JK_TOGGLE_PREF_EN when computing expected excitation.
module tb_jk_excitation_driver;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] tgt;
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             drv_en;
  logic             done;
  logic             match;
  logic [CNT_W-1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] stuck0_mask = '0;
  int               err_model   = 0;

  jk_excitation_driver #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt       (tgt),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .q_fb      (q_fb),
    .j         (j),
    .k         (k),
    .drv_en    (drv_en),
    .done      (done),
    .match     (match),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench JK bank: characteristic equation Q+ = J~Q | ~K Q, with forced-low faults.
  always @(posedge clk or posedge rst) begin
    if (rst) q_fb <= '0;
    else if (drv_en) q_fb <= ((j & ~q_fb) | (~k & q_fb)) & ~stuck0_mask;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] exp_j(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] t);
`ifdef JK_TOGGLE_PREF_EN
    return q ^ t;
`else
    return ~q & t;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] exp_k(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] t);
`ifdef JK_TOGGLE_PREF_EN
    return q ^ t;
`else
    return q & ~t;
`endif
  endfunction

  // One full transfer starting in IDLE at posedge+1; verbose selects per-step printing.
  task automatic xfer(input logic [WIDTH-1:0] t, input bit verbose);
    logic [WIDTH-1:0] q0;
    logic             m_exp;
    q0 = q_fb;
    tgt = t;
    tgt_valid = 1'b1;
    chk("idle_ready", tgt_ready, 1);
    @(posedge clk); #1;
    tgt_valid = 1'b0;
    chk("drive_en", drv_en, 1);
    chk("drive_j", j, exp_j(q0, t));
    chk("drive_k", k, exp_k(q0, t));
    chk("drive_ready", tgt_ready, 0);
    chk("drive_done", done, 0);
    @(posedge clk); #1;
    m_exp = ((t & ~stuck0_mask) == t);
    chk("check_done", done, 1);
    chk("check_match", match, m_exp);
    chk("check_j", j, 0);
    chk("check_k", k, 0);
    chk("check_en", drv_en, 0);
    if (!m_exp && err_model < 255) err_model++;
    @(posedge clk); #1;
    chk("err_cnt", err_cnt, err_model);
    chk("post_done", done, 0);
    if (verbose)
      $display("xfer q=%b tgt=%b match_exp=%0d err_cnt=%0d", q0, t, m_exp, err_cnt);
  endtask

  initial begin
    rst = 1'b1;
    tgt = '0;
    tgt_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_j", j, 0);
    chk("rst_k", k, 0);
    chk("rst_en", drv_en, 0);
    chk("rst_done", done, 0);
    chk("rst_match", match, 0);
    chk("rst_err", err_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed transfers from the test plan.
    xfer(4'b1010, 1'b1);
    chk("q_after_1010", q_fb, 4'b1010);
    xfer(4'b0110, 1'b1);
    xfer(4'b0110, 1'b1);

    // Random targets against the reference model.
    for (int i = 0; i < 40; i++) xfer(4'($urandom_range(0, 15)), 1'b1);

    // Stuck-at-0 bit 0: every transfer to 1111 mismatches; counter saturates.
    stuck0_mask = 4'b0001;
    xfer(4'b1111, 1'b1);
    chk("first_err", err_cnt, 1);
    for (int i = 1; i < 300; i++) xfer(4'b1111, 1'b0);
    chk("err_sat", err_cnt, 255);
    $display("stuck run done err_cnt=%0d", err_cnt);
    stuck0_mask = '0;

    // Streaming: tgt_valid held high; ready 1,0,0 and done every third cycle.
    tgt = 4'($urandom_range(0, 15));
    tgt_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("stream_ready", tgt_ready, (i % 3 == 0) ? 1 : 0);
      chk("stream_done", done, (i % 3 == 2) ? 1 : 0);
      if (i % 3 == 2) chk("stream_match", match, 1);
      $display("stream cycle=%0d ready=%0d done=%0d", i, tgt_ready, done);
      @(posedge clk); #1;
      if (i % 3 == 0) tgt = 4'($urandom_range(0, 15));
    end
    tgt_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream_err", err_cnt, 255);

    // Async reset during DRIVE aborts the transfer without a done.
    tgt = 4'b0101;
    tgt_valid = 1'b1;
    @(posedge clk); #1;
    tgt_valid = 1'b0;
    chk("abort_in_drive", drv_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_j", j, 0);
    chk("abort_k", k, 0);
    chk("abort_en", drv_en, 0);
    chk("abort_done", done, 0);
    #2 rst = 1'b0;
    err_model = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_ready", tgt_ready, 1);
      chk("abort_no_done", done, 0);
    end
    chk("abort_err", err_cnt, 0);
    $display("abort sequence done");

    // Back in service after the abort.
    xfer(4'b1001, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
